uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_transmitter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// uart_transmitter: 8-bit serial transmitter, start bit, LSB-first data,
// optional even-parity bit, one stop bit. Each bit lasts 16 pulses of the
// 16x-oversampling enable produced by baud_controller.
//
// Build option: define UART_TX_PARITY_EN to send the parity bit
// (11-bit frames). Left undefined, frames are 10 bits (no parity).
//
// Handshake: a write is a one-cycle Tx_WR pulse. It is accepted only when
// the transmitter sits in IDLE with Tx_EN=1; Tx_BUSY rises on the accepting
// edge and falls on the edge that ends the stop bit. Writes seen while
// Tx_BUSY=1, on the edge Tx_BUSY falls, or while disabled are dropped.

// baud_controller: free-running divider producing a one-cycle sample_ENABLE
// pulse at 16x the selected baud rate (dividers assume a 50 MHz clk).
module baud_controller (
    input  logic       reset,
    input  logic       clk,
    input  logic [2:0] baud_select,
    output logic       sample_ENABLE
);

    logic [13:0] limit;
    logic [13:0] cnt_q, cnt_d;
    logic        pulse_q, pulse_d;

    // Terminal count (divider - 1) for each baud code.
    always_comb begin
        case (baud_select)
            3'd0:    limit = 14'd10416; // 300
            3'd1:    limit = 14'd2603;  // 1200
            3'd2:    limit = 14'd650;   // 4800
            3'd3:    limit = 14'd325;   // 9600
            3'd4:    limit = 14'd162;   // 19200
            3'd5:    limit = 14'd80;    // 38400
            3'd6:    limit = 14'd53;    // 57600
            default: limit = 14'd26;    // 115200
        endcase
    end

    // Count up and wrap at or past the terminal count, so a switch to a
    // faster rate never has to run the counter all the way round.
    always_comb begin
        cnt_d   = cnt_q + 14'd1;
        pulse_d = 1'b0;
        if (cnt_q >= limit) begin
            cnt_d   = '0;
            pulse_d = 1'b1;
        end
    end

    // Divider state; the pulse is registered so it is glitch-free.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
        end
    end

    assign sample_ENABLE = pulse_q;

endmodule

module uart_transmitter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] Tx_DATA,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    output logic       TxD,
    output logic       Tx_BUSY
);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] tick_q, tick_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic [7:0] data_q, data_d;
    logic       txd_q, txd_d;
    logic       busy_q, busy_d;

    logic       sample_enable;
    logic       bit_end;
    logic       in_frame;
    logic [2:0] next_idx;

    baud_controller u_baud (
        .reset         (reset),
        .clk           (clk),
        .baud_select   (baud_select),
        .sample_ENABLE (sample_enable)
    );

    // A bit ends on the 16th sample pulse, i.e. the pulse that wraps 15->0.
    assign bit_end  = sample_enable && (tick_q == 4'd15);
    assign in_frame = (state_q == S_START) || (state_q == S_DATA) ||
                      (state_q == S_PARITY) || (state_q == S_STOP);
    assign next_idx = bit_idx_q + 3'd1;

    // Next-state, next-output and datapath updates for the transmit FSM.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_idx_d = bit_idx_q;
        data_d    = data_q;
        txd_d     = txd_q;
        busy_d    = busy_q;

        // The tick counter runs only while a frame is in flight.
        if (in_frame && sample_enable) begin
            tick_d = tick_q + 4'd1;
        end

        case (state_q)
            S_OFF: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (Tx_EN) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                txd_d  = 1'b1;
                busy_d = 1'b0;
                if (!Tx_EN) begin
                    state_d = S_OFF;
                end else if (Tx_WR) begin
                    // Accept: latch the byte and begin the start bit now.
                    data_d    = Tx_DATA;
                    state_d   = S_START;
                    txd_d     = 1'b0;
                    busy_d    = 1'b1;
                    tick_d    = 4'd0;
                    bit_idx_d = 3'd0;
                end
            end

            S_START: begin
                if (bit_end) begin
                    state_d   = S_DATA;
                    bit_idx_d = 3'd0;
                    txd_d     = data_q[0];
                end
            end

            S_DATA: begin
                if (bit_end) begin
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        txd_d   = ^data_q;
`else
                        state_d = S_STOP;
                        txd_d   = 1'b1;
`endif
                    end else begin
                        bit_idx_d = next_idx;
                        txd_d     = data_q[next_idx];
                    end
                end
            end

            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                    txd_d   = 1'b1;
                end
            end

            S_STOP: begin
                txd_d = 1'b1;
                if (bit_end) begin
                    // Tx_EN is only consulted here, so a mid-frame disable
                    // still lets the frame finish.
                    state_d = Tx_EN ? S_IDLE : S_OFF;
                    busy_d  = 1'b0;
                end
            end

            default: begin
                state_d   = S_OFF;
                txd_d     = 1'b1;
                busy_d    = 1'b0;
                tick_d    = 4'd0;
                bit_idx_d = 3'd0;
            end
        endcase
    end

    // State, counters, data latch and registered line outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_OFF;
            tick_q    <= 4'd0;
            bit_idx_q <= 3'd0;
            data_q    <= 8'h00;
            txd_q     <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_idx_q <= bit_idx_d;
            data_q    <= data_d;
            txd_q     <= txd_d;
            busy_q    <= busy_d;
        end
    end

    assign TxD     = txd_q;
    assign Tx_BUSY = busy_q;

endmodule

// File: tb/tb_uart_transmitter.sv
// Testbench for uart_transmitter. Reference model: a frame is a list of
// line levels (start, data LSB first, optional parity, stop), each held for
// 16 sample pulses; the first bit may be up to one pulse period shorter
// because the baud divider free-runs relative to the write.
module tb_uart_transmitter;

  localparam int DIV     = 27;          // clk cycles per sample pulse, code 7
  localparam int BIT_CYC = 16 * DIV;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS   = 11;
`else
  localparam int NBITS   = 10;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] tx_data;
  logic [2:0] baud_select;
  logic       tx_en;
  logic       tx_wr;
  logic       txd;
  logic       busy;

  int n_checks;
  int n_fail;

  logic       cap_q[$];
  logic [0:0] exp_q[$];

  typedef struct packed {
    logic       rst;
    logic       en;
    logic       wr;
    logic [7:0] data;
    logic       exp_txd;
    logic       exp_busy;
  } vec_t;

  vec_t vecs[7];

  uart_transmitter dut (
    .clk         (clk),
    .reset       (reset),
    .Tx_DATA     (tx_data),
    .baud_select (baud_select),
    .Tx_EN       (tx_en),
    .Tx_WR       (tx_wr),
    .TxD         (txd),
    .Tx_BUSY     (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, failures so far %0d", n_fail);
    $fatal(1);
  end

  task automatic check(input bit ok, input string what, input int act, input int exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", what, act, exp);
    end
  endtask

  // driver: one write strobe; line data is scrambled afterwards
  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    tx_data = b;
    tx_wr   = 1'b1;
    @(posedge clk);
    #1;
    tx_wr   = 1'b0;
    tx_data = 8'($urandom);
    check(busy == 1'b1, "accept_busy", int'(busy), 1);
  endtask

  // record TxD every cycle while Tx_BUSY is high
  task automatic capture_frame();
    int guard;
    cap_q.delete();
    cap_q.push_back(txd);
    guard = 0;
    while (1) begin
      @(posedge clk);
      #1;
      if (!busy) break;
      cap_q.push_back(txd);
      guard++;
      if (guard > NBITS * BIT_CYC + 50) begin
        check(1'b0, "frame_timeout", guard, NBITS * BIT_CYC);
        return;
      end
    end
    check(txd == 1'b1, "idle_after_stop", int'(txd), 1);
  endtask

  // scoreboard: compare captured waveform against the model frame
  task automatic check_frame(input logic [7:0] b);
    int len, first, pos, w, errs;
    exp_q.delete();
    exp_q.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_q.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    exp_q.push_back(^b);
`endif
    exp_q.push_back(1'b1);
    len   = cap_q.size();
    first = len - (exp_q.size() - 1) * BIT_CYC;
    check(first >= BIT_CYC - DIV + 1 && first <= BIT_CYC, "frame_len_cycles",
          len, NBITS * BIT_CYC);
    if (first >= BIT_CYC - DIV + 1 && first <= BIT_CYC) begin
      pos = 0;
      for (int k = 0; k < exp_q.size(); k++) begin
        w    = (k == 0) ? first : BIT_CYC;
        errs = 0;
        for (int j = 0; j < w; j++) begin
          if (cap_q[pos + j] !== exp_q[k][0]) errs++;
        end
        pos += w;
        n_checks++;
        if (errs != 0) begin
          n_fail++;
          $display("FAIL frame 0x%02h bit %0d: %0d samples differ, required level %0b",
                   b, k, errs, exp_q[k][0]);
        end
      end
    end
  endtask

  task automatic send_and_check(input logic [7:0] b);
    write_byte(b);
    capture_frame();
    check_frame(b);
  endtask

  initial begin
    int hits;
    logic [7:0] rb;
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b1;
    tx_en       = 1'b0;
    tx_wr       = 1'b0;
    tx_data     = 8'h00;
    baud_select = 3'd7;

    // reset and enable sequencing, one row per clk cycle
    vecs[0] = '{rst:1'b1, en:1'b0, wr:1'b0, data:8'h00, exp_txd:1'b1, exp_busy:1'b0};
    vecs[1] = '{rst:1'b1, en:1'b1, wr:1'b1, data:8'hAA, exp_txd:1'b1, exp_busy:1'b0};
    vecs[2] = '{rst:1'b0, en:1'b0, wr:1'b1, data:8'h11, exp_txd:1'b1, exp_busy:1'b0};
    vecs[3] = '{rst:1'b0, en:1'b1, wr:1'b1, data:8'h22, exp_txd:1'b1, exp_busy:1'b0};
    vecs[4] = '{rst:1'b0, en:1'b0, wr:1'b1, data:8'h33, exp_txd:1'b1, exp_busy:1'b0};
    vecs[5] = '{rst:1'b0, en:1'b1, wr:1'b0, data:8'h44, exp_txd:1'b1, exp_busy:1'b0};
    vecs[6] = '{rst:1'b0, en:1'b1, wr:1'b0, data:8'h55, exp_txd:1'b1, exp_busy:1'b0};

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      reset   = vecs[i].rst;
      tx_en   = vecs[i].en;
      tx_wr   = vecs[i].wr;
      tx_data = vecs[i].data;
      @(posedge clk);
      #1;
      check(txd == vecs[i].exp_txd, $sformatf("vec%0d_txd", i), int'(txd), int'(vecs[i].exp_txd));
      check(busy == vecs[i].exp_busy, $sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].exp_busy));
    end
    tx_wr = 1'b0;

    // basic frames
    send_and_check(8'h55);
    repeat (5) @(posedge clk);
    send_and_check(8'hA7);
    repeat (3) @(posedge clk);

    // write during a frame is dropped, nothing queued
    write_byte(8'h3C);
    fork
      capture_frame();
      begin
        repeat (40 * DIV) @(posedge clk);
        @(negedge clk);
        tx_data = 8'hFF;
        tx_wr   = 1'b1;
        @(negedge clk);
        tx_wr   = 1'b0;
      end
    join
    check_frame(8'h3C);
    hits = 0;
    repeat (100) begin
      @(posedge clk);
      #1;
      if (busy) hits++;
    end
    check(hits == 0, "no_second_frame", hits, 0);

    // disable mid-frame: frame completes, then transmitter is off
    write_byte(8'h81);
    fork
      capture_frame();
      begin
        repeat ((16 + 3 * 16 + 8) * DIV) @(posedge clk);
        @(negedge clk);
        tx_en = 1'b0;
      end
    join
    check_frame(8'h81);
    @(negedge clk);
    tx_wr = 1'b1;
    @(negedge clk);
    tx_wr = 1'b0;
    hits = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (busy) hits++;
    end
    check(hits == 0, "off_ignores_write", hits, 0);
    // from OFF, enable plus write in one cycle only wakes to IDLE
    @(negedge clk);
    tx_en = 1'b1;
    tx_wr = 1'b1;
    @(posedge clk);
    #1;
    tx_wr = 1'b0;
    check(busy == 1'b0, "off_wake_no_accept", int'(busy), 0);

    // asynchronous reset in data bit 5
    write_byte(8'hC3);
    repeat ((16 + 5 * 16 + 8) * DIV) @(posedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check(txd == 1'b1, "async_reset_txd", int'(txd), 1);
    check(busy == 1'b0, "async_reset_busy", int'(busy), 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check(busy == 1'b0, "post_reset_idle", int'(busy), 0);
    send_and_check(8'h00);
    repeat (4) @(posedge clk);

    // back-to-back: second write in the first cycle Tx_BUSY=0 is visible
    send_and_check(8'h12);
    send_and_check(8'h34);

    // randomized bytes and gaps
    for (int r = 0; r < 4; r++) begin
      repeat ($urandom_range(1, 20)) @(posedge clk);
      rb = 8'($urandom);
      send_and_check(rb);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
